// File: rtl/core_run_ctrl.sv
// Run sequencer for a bank of vector cores: hold in reset, run until every core reports done,
// then stream each core's data memory out. Optional RUN watchdog: define CORE_RUN_CTRL_TIMEOUT_EN.
module core_run_ctrl #(
    parameter int NUM_CORES      = 4,
    parameter int DATA_MEM_SIZE  = 256,
    parameter int RESET_CYCLES   = 1,
    parameter int SETTLE_CYCLES  = 1,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int CORE_ADDR_SIZE = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1,
    parameter int MEM_ADDR_SIZE  = (DATA_MEM_SIZE > 1) ? $clog2(DATA_MEM_SIZE) : 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    output logic [NUM_CORES-1:0]      core_reset,
    input  logic [NUM_CORES-1:0]      core_done,
    output logic                      mem_rd_en,
    output logic [CORE_ADDR_SIZE-1:0] mem_rd_core,
    output logic [MEM_ADDR_SIZE-1:0]  mem_rd_addr,
    input  logic [31:0]               mem_rd_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [31:0]               out_data,
    output logic [CORE_ADDR_SIZE-1:0] out_core,
    output logic [MEM_ADDR_SIZE-1:0]  out_addr,
    output logic                      busy,
    output logic                      finished,
    output logic                      timed_out
);

    if (NUM_CORES < 1 || NUM_CORES > 16 || DATA_MEM_SIZE < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("core_run_ctrl: parameter out of range");
    end

    // One down-counter serves both RESET_HOLD and SETTLE, sized for the longer of the two.
    localparam int PH_MAX = (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES;
    localparam int PH_W   = (PH_MAX < 2) ? 1 : $clog2(PH_MAX + 1);

    localparam logic [CORE_ADDR_SIZE-1:0] LAST_CORE = CORE_ADDR_SIZE'(NUM_CORES - 1);
    localparam logic [MEM_ADDR_SIZE-1:0]  LAST_ADDR = MEM_ADDR_SIZE'(DATA_MEM_SIZE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET_HOLD,
        S_RUN,
        S_SETTLE,
        S_DUMP_RD,
        S_DUMP_OUT,
        S_DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [PH_W-1:0]           phase_q, phase_d;
    logic [NUM_CORES-1:0]      sticky_q, sticky_d;
    logic [NUM_CORES-1:0]      done_prev_q;
    logic [NUM_CORES-1:0]      done_rise;
    logic [NUM_CORES-1:0]      core_reset_q, core_reset_d;
    logic [CORE_ADDR_SIZE-1:0] rd_core_q, rd_core_d;
    logic [MEM_ADDR_SIZE-1:0]  rd_addr_q, rd_addr_d;
    logic                      out_valid_q, out_valid_d;
    logic [31:0]               out_data_q, out_data_d;
    logic [CORE_ADDR_SIZE-1:0] out_core_q, out_core_d;
    logic [MEM_ADDR_SIZE-1:0]  out_addr_q, out_addr_d;
    logic                      finished_q, finished_d;

`ifdef CORE_RUN_CTRL_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] run_cnt_q, run_cnt_d;
    logic            timed_out_q, timed_out_d;
`endif

    // Edge detection runs every cycle, so a level already high when RUN begins is not an edge.
    assign done_rise = core_done & ~done_prev_q;

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        sticky_d     = sticky_q;
        core_reset_d = core_reset_q;
        rd_core_d    = rd_core_q;
        rd_addr_d    = rd_addr_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_core_d   = out_core_q;
        out_addr_d   = out_addr_q;
        finished_d   = finished_q;
`ifdef CORE_RUN_CTRL_TIMEOUT_EN
        run_cnt_d    = run_cnt_q;
        timed_out_d  = timed_out_q;
`endif

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d      = S_RESET_HOLD;
                    core_reset_d = '1;
                    phase_d      = PH_W'(RESET_CYCLES);
                    sticky_d     = '0;
                    finished_d   = 1'b0;
`ifdef CORE_RUN_CTRL_TIMEOUT_EN
                    timed_out_d  = 1'b0;
`endif
                end
            end

            S_RESET_HOLD: begin
                if (phase_q <= PH_W'(1)) begin
                    state_d      = S_RUN;
                    core_reset_d = '0;
`ifdef CORE_RUN_CTRL_TIMEOUT_EN
                    run_cnt_d    = '0;
`endif
                end else begin
                    phase_d = phase_q - 1'b1;
                end
            end

            S_RUN: begin
                sticky_d = sticky_q | done_rise;
                if (&sticky_d) begin
                    state_d = S_SETTLE;
                    phase_d = PH_W'(SETTLE_CYCLES);
                end
`ifdef CORE_RUN_CTRL_TIMEOUT_EN
                // Watchdog: park the cores in reset so the dump captures a frozen image.
                else if (run_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d      = S_SETTLE;
                    phase_d      = PH_W'(SETTLE_CYCLES);
                    timed_out_d  = 1'b1;
                    core_reset_d = '1;
                end else begin
                    run_cnt_d = run_cnt_q + 1'b1;
                end
`endif
            end

            S_SETTLE: begin
                if (phase_q <= PH_W'(1)) begin
                    state_d   = S_DUMP_RD;
                    rd_core_d = '0;
                    rd_addr_d = '0;
                end else begin
                    phase_d = phase_q - 1'b1;
                end
            end

            S_DUMP_RD: begin
                state_d = S_DUMP_OUT;
            end

            S_DUMP_OUT: begin
                // First DUMP_OUT cycle is the read-return cycle; out_valid is still low then.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    out_data_d  = mem_rd_data;
                    out_core_d  = rd_core_q;
                    out_addr_d  = rd_addr_q;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (rd_core_q == LAST_CORE && rd_addr_q == LAST_ADDR) begin
                        state_d    = S_DONE;
                        finished_d = 1'b1;
                    end else begin
                        state_d = S_DUMP_RD;
                        if (rd_addr_q == LAST_ADDR) begin
                            rd_addr_d = '0;
                            rd_core_d = rd_core_q + 1'b1;
                        end else begin
                            rd_addr_d = rd_addr_q + 1'b1;
                        end
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        done_prev_q <= core_done;
        if (reset) begin
            state_q      <= S_IDLE;
            phase_q      <= '0;
            sticky_q     <= '0;
            core_reset_q <= '1;
            rd_core_q    <= '0;
            rd_addr_q    <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_core_q   <= '0;
            out_addr_q   <= '0;
            finished_q   <= 1'b0;
`ifdef CORE_RUN_CTRL_TIMEOUT_EN
            run_cnt_q    <= '0;
            timed_out_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            sticky_q     <= sticky_d;
            core_reset_q <= core_reset_d;
            rd_core_q    <= rd_core_d;
            rd_addr_q    <= rd_addr_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_core_q   <= out_core_d;
            out_addr_q   <= out_addr_d;
            finished_q   <= finished_d;
`ifdef CORE_RUN_CTRL_TIMEOUT_EN
            run_cnt_q    <= run_cnt_d;
            timed_out_q  <= timed_out_d;
`endif
        end
    end

    assign core_reset  = core_reset_q;
    assign mem_rd_en   = (state_q == S_DUMP_RD);
    assign mem_rd_core = rd_core_q;
    assign mem_rd_addr = rd_addr_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_core    = out_core_q;
    assign out_addr    = out_addr_q;
    assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
    assign finished    = finished_q;
`ifdef CORE_RUN_CTRL_TIMEOUT_EN
    assign timed_out   = timed_out_q;
`else
    assign timed_out   = 1'b0;
`endif

endmodule

// File: tb/tb_core_run_ctrl.sv
// Bench for core_run_ctrl: directed scenarios plus randomized runs against a behavioural model.
module tb_core_run_ctrl;
    localparam int NC    = 2;
    localparam int DMS   = 4;
    localparam int RST_C = 1;
    localparam int SET_C = 1;
    localparam int TO_C  = 20;
    localparam int TOTAL = NC * DMS;
`ifdef CORE_RUN_CTRL_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          out_ready = 1'b1;
    logic [NC-1:0] core_done = '0;
    logic [NC-1:0] core_reset;
    logic          mem_rd_en;
    logic [0:0]    mem_rd_core;
    logic [1:0]    mem_rd_addr;
    logic [31:0]   mem_rd_data = '0;
    logic          out_valid;
    logic [31:0]   out_data;
    logic [0:0]    out_core;
    logic [1:0]    out_addr;
    logic          busy, finished, timed_out;

    core_run_ctrl #(
        .NUM_CORES(NC), .DATA_MEM_SIZE(DMS), .RESET_CYCLES(RST_C),
        .SETTLE_CYCLES(SET_C), .TIMEOUT_CYCLES(TO_C)
    ) dut (
        .clock(clock), .reset(reset), .start(start),
        .core_reset(core_reset), .core_done(core_done),
        .mem_rd_en(mem_rd_en), .mem_rd_core(mem_rd_core), .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_core(out_core), .out_addr(out_addr),
        .busy(busy), .finished(finished), .timed_out(timed_out)
    );

    logic [31:0] mem [TOTAL];
    int cyc = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;
    // Memory returns data one cycle after the strobe; garbage on every other cycle.
    always @(posedge clock)
        mem_rd_data <= mem_rd_en ? mem[int'(mem_rd_core) * DMS + int'(mem_rd_addr)] : $urandom;

    // Stimulus-side controls (written only by the stimulus process).
    int test_id = 0;
    int ready_low = 0;
    bit rnd_ready = 1'b0;
    int tmo_cnt = 0;
    bit final_req = 1'b0;

    // Model and scoreboard (written only by the checker process).
    int checks = 0;
    int errors = 0;
    int m_mode = 0;   // 0 idle, 1 reset hold, 2 run, 3 settle+dump, 4 done
    int hold_left = 0, run_cyc = 0, settle_left = 0, ph = 0, m_beat = 0, start_cyc = 0;
    int n_rd = 0, n_hs = 0;
    logic [NC-1:0] m_sticky = '0, m_prev = '0, rise;
    bit m_fin = 1'b0, m_to = 1'b0, first_rd_seen = 1'b0, to_seen = 1'b0;
    bit rst_lit_pending = 1'b0, final_done = 1'b0;
    logic [31:0] beat0_data = '0, beat7_data = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic enter_post();
        m_mode = 3;
        settle_left = SET_C;
        ph = 0;
        m_beat = 0;
    endtask

    always @(negedge clock) begin
        if (cyc >= 1) begin
            if (mem_rd_en === 1'b1) n_rd++;
            if (out_valid === 1'b1 && out_ready) begin
                if (test_id == 1 && n_hs == 0) beat0_data = out_data;
                if (test_id == 1 && n_hs == 7) beat7_data = out_data;
                n_hs++;
            end

            // Control/status outputs against the model.
            chk("busy", busy, 64'(m_mode inside {1, 2, 3}));
            chk("finished", finished, 64'(m_fin));
            chk("timed_out", timed_out, 64'(m_to));
            chk("core_reset", core_reset, (m_mode <= 1 || m_to) ? {NC{1'b1}} : '0);

            if (m_mode == 3 && settle_left == 0) begin
                case (ph)
                    0: begin
                        chk("rd_en", mem_rd_en, 1);
                        chk("rd_core", mem_rd_core, m_beat / DMS);
                        chk("rd_addr", mem_rd_addr, m_beat % DMS);
                        chk("out_valid", out_valid, 0);
                        if (!first_rd_seen) begin
                            first_rd_seen = 1'b1;
                            if (test_id == 1) chk("settle_latency", cyc - start_cyc, 16);
                        end
                    end
                    1: begin
                        chk("rd_en", mem_rd_en, 0);
                        chk("out_valid", out_valid, 0);
                    end
                    default: begin
                        chk("rd_en", mem_rd_en, 0);
                        chk("out_valid", out_valid, 1);
                        chk("out_core", out_core, m_beat / DMS);
                        chk("out_addr", out_addr, m_beat % DMS);
                        chk("out_data", out_data, mem[m_beat]);
                    end
                endcase
            end else begin
                chk("rd_en", mem_rd_en, 0);
                chk("out_valid", out_valid, 0);
            end

            // Hand-computed literals pinning the model.
            if (cyc == 2) begin
                chk("reset_core_reset", core_reset, 2'b11);
                chk("reset_out_fields", {out_data, out_core, out_addr}, 0);
                chk("reset_rd_target", {mem_rd_core, mem_rd_addr}, 0);
            end
            if (rst_lit_pending) begin
                rst_lit_pending = 1'b0;
                chk("middump_reset_state", {out_valid, busy, core_reset}, 4'b0011);
            end
            if (test_id == 2 && cyc - start_cyc == 12)
                chk("held_done_ignored", {mem_rd_en, out_valid, finished, busy}, 4'b0001);
            if (test_id == 5 && timed_out === 1'b1 && !to_seen) begin
                to_seen = 1'b1;
                chk("timeout_latency", cyc - start_cyc, 21);
            end
            if (test_id == 5 && !TO_EN && cyc - start_cyc == 1000)
                chk("busy_after_1000", busy, 1);
            if (final_req && !final_done) begin
                final_done = 1'b1;
                chk("wait_bounds", tmo_cnt, 0);
            end

            // Advance the model with the inputs the next edge will sample.
            if (reset) begin
                if (test_id == 4 && m_mode == 3) rst_lit_pending = 1'b1;
                m_mode = 0;
                m_fin = 1'b0;
                m_to = 1'b0;
                m_sticky = '0;
            end else begin
                case (m_mode)
                    0, 4: if (start) begin
                        m_mode = 1;
                        hold_left = RST_C;
                        m_fin = 1'b0;
                        m_to = 1'b0;
                        m_sticky = '0;
                        start_cyc = cyc + 1;
                        first_rd_seen = 1'b0;
                        n_rd = 0;
                        n_hs = 0;
                    end
                    1: begin
                        hold_left--;
                        if (hold_left <= 0) begin
                            m_mode = 2;
                            run_cyc = 0;
                        end
                    end
                    2: begin
                        rise = core_done & ~m_prev;
                        m_sticky = m_sticky | rise;
                        run_cyc++;
                        if (&m_sticky) enter_post();
                        else if (TO_EN && run_cyc == TO_C) begin
                            m_to = 1'b1;
                            enter_post();
                        end
                    end
                    3: begin
                        if (settle_left > 0) settle_left--;
                        else if (ph == 0) ph = 1;
                        else if (ph == 1) ph = 2;
                        else if (out_ready) begin
                            m_beat++;
                            if (m_beat == TOTAL) begin
                                m_mode = 4;
                                m_fin = 1'b1;
                                chk("dump_reads", n_rd, TOTAL);
                                chk("dump_beats", n_hs, TOTAL);
                                if (test_id == 1) begin
                                    chk("first_beat_data", beat0_data, 32'h3F80_0000);
                                    chk("last_beat_data", beat7_data, 32'h3F80_0013);
                                end
                            end else begin
                                ph = 0;
                            end
                        end
                    end
                    default: m_mode = 0;
                endcase
            end
            m_prev = core_done;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
        if (ready_low > 0) begin
            out_ready = 1'b0;
            ready_low--;
        end else begin
            out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    endtask

    task automatic start_pulse();
        step();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic pulse_all(input int delay);
        repeat (delay) step();
        core_done = '1;
        step();
        core_done = '0;
    endtask

    task automatic wait_mode(input int target, input int limit);
        int n = 0;
        while (m_mode != target && n < limit) begin
            step();
            n++;
        end
        if (m_mode != target) begin
            tmo_cnt++;
            $display("FAIL wait_mode test %0d: mode %0d, wanted %0d", test_id, m_mode, target);
        end
    endtask

    task automatic wait_beat(input int beat, input int phase, input int limit);
        int n = 0;
        while (!(m_mode == 3 && m_beat == beat && ph == phase) && n < limit) begin
            step();
            n++;
        end
        if (n >= limit) begin
            tmo_cnt++;
            $display("FAIL wait_beat test %0d: beat %0d phase %0d not reached", test_id, beat, phase);
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < TOTAL; i++) mem[i] = $urandom;
    endtask

    initial begin
        for (int i = 0; i < TOTAL; i++) mem[i] = 32'h3F80_0000 + 32'((i / DMS) * 16 + (i % DMS));
        repeat (3) step();
        reset = 1'b0;
        step();

        // Basic run: core0 done edge at cycle 10, core1 at 15.
        test_id = 1;
        start_pulse();
        repeat (9) step();
        core_done = 2'b01;
        step();
        core_done = 2'b00;
        repeat (4) step();
        core_done = 2'b10;
        step();
        core_done = 2'b00;
        wait_mode(4, 200);

        // core_done[0] high through reset hold; only a fresh rising edge counts.
        test_id = 2;
        fill_random();
        core_done = 2'b01;
        start_pulse();
        repeat (4) step();
        core_done = 2'b11;
        step();
        core_done = 2'b01;
        repeat (8) step();
        core_done = 2'b00;
        repeat (2) step();
        core_done = 2'b01;
        step();
        core_done = 2'b00;
        wait_mode(4, 200);

        // Backpressure: out_ready low for 5 cycles while beat 3 is presented.
        test_id = 3;
        fill_random();
        start_pulse();
        pulse_all(3);
        wait_beat(3, 1, 200);
        ready_low = 5;
        wait_mode(4, 200);

        // Reset mid-dump at beat 5, then a complete restart.
        test_id = 4;
        fill_random();
        start_pulse();
        pulse_all(2);
        wait_beat(5, 2, 200);
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        test_id = 41;
        start_pulse();
        pulse_all(4);
        wait_mode(4, 200);

        // core1 never finishes.
        test_id = 5;
        fill_random();
        start_pulse();
        repeat (3) step();
        core_done = 2'b01;
        step();
        core_done = 2'b00;
`ifdef CORE_RUN_CTRL_TIMEOUT_EN
        wait_mode(4, 300);
`else
        repeat (1005) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
`endif

        // Randomized runs: random done timing/levels, random backpressure, ignored starts, one reset.
        test_id = 6;
        rnd_ready = 1'b1;
        for (int r = 0; r < 6; r++) begin
            int t0, t1, l0, l1;
            fill_random();
            t0 = $urandom_range(1, 24);
            t1 = $urandom_range(1, 24);
            l0 = $urandom_range(1, 3);
            l1 = $urandom_range(1, 3);
            start_pulse();
            for (int i = 1; i <= 28; i++) begin
                core_done[0] = (i >= t0 && i < t0 + l0);
                core_done[1] = (i >= t1 && i < t1 + l1);
                start = (i == 6);
                step();
            end
            core_done = '0;
            start = 1'b0;
            if (r == 3) begin
                repeat ($urandom_range(0, 15)) step();
                reset = 1'b1;
                step();
                reset = 1'b0;
                step();
            end else begin
                wait_mode(4, 400);
            end
        end

        rnd_ready = 1'b0;
        step();
        final_req = 1'b1;
        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

endmodule
